// File: rtl/enum_type.sv
// Shared command encoding and default gravity timing for the game front end.
// Contents:
//   state_type       - command codes passed from input decoders to the game core
//   DefaultTick*     - gravity period defaults (cycles); top level and control_queue agree on these
package enum_type;

  typedef enum logic [3:0] {
    NONE       = 4'd0,
    LEFT       = 4'd1,
    RIGHT      = 4'd2,
    DOWN       = 4'd3,
    DROP       = 4'd4,
    HOLD       = 4'd5,
    ROTATE     = 4'd6,
    ROTATE_REV = 4'd7,
    BAR        = 4'd8,
    WAIT       = 4'd9
  } state_type;

  localparam int unsigned DefaultTickBase = 50_000_000;
  localparam int unsigned DefaultTickStep = 3_000_000;
  localparam int unsigned DefaultTickMin  = 5_000_000;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: power-of-two storage with natural pointer wrap and a one-bit-wider
// occupancy count so full and empty are distinct.
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   flush_i       - clears pointers and count; overrides push and pop
//   push_i        - write wdata_i (refused when full unless popping the same cycle)
//   pop_i         - consume head entry (ignored when empty)
//   rdata_o       - head entry, NONE when empty
//   valid_o       - queue non-empty
//   full_o        - queue holds Depth entries
//   count_o       - occupancy
module cmd_fifo
  import enum_type::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  state_type                wdata_i,
  input  logic                     pop_i,
  output state_type                rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  state_type        mem_q [Depth];
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign do_pop  = pop_i & valid_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : NONE;
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AddrW+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (AddrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are gated to NONE while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/control_queue.sv
// Game-command front end: fixed-priority arbitration of NSRC command strobes plus a
// level-dependent gravity timer into one FIFO, drained by the game core over valid/ready.
// Build option: define CTRL_GRAVITY_EN to build the gravity timer; otherwise level_i is
// ignored and only external sources are arbitrated. Ports are identical in both builds.
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset (also clears sticky flags)
//   src_valid_i    - per-source one-cycle command strobe (source 0 highest priority)
//   src_cmd_i      - per-source command
//   level_i        - game level; shortens the gravity period
//   flush_i        - clears queue and gravity state; sticky flags kept
//   cmd_ready_i    - consumer accepts head entry
//   cmd_valid_o    - queue non-empty
//   cmd_o          - head entry, NONE when empty
//   count_o        - occupancy
//   overflow_o     - sticky: a winning external command was lost to a full queue
//   dropped_o      - sticky: a valid external source lost arbitration
module control_queue
  import enum_type::*;
#(
  parameter int unsigned QDEPTH    = 16,
  parameter int unsigned NSRC      = 4,
  parameter int unsigned LEVEL_W   = 4,
  parameter int unsigned TICK_BASE = DefaultTickBase,
  parameter int unsigned TICK_STEP = DefaultTickStep,
  parameter int unsigned TICK_MIN  = DefaultTickMin
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NSRC-1:0]           src_valid_i,
  input  state_type [NSRC-1:0]      src_cmd_i,
  input  logic [LEVEL_W-1:0]        level_i,
  input  logic                      flush_i,
  input  logic                      cmd_ready_i,
  output logic                      cmd_valid_o,
  output state_type                 cmd_o,
  output logic [$clog2(QDEPTH):0]   count_o,
  output logic                      overflow_o,
  output logic                      dropped_o
);

  logic      grav_req;
  logic      win_any, win_ext, lost_ext;
  state_type win_cmd;
  logic      fifo_full, pop, push;
  logic      overflow_q, dropped_q;

  // Lowest-index external candidate wins; gravity is the lowest-priority candidate.
  always_comb begin
    win_any  = 1'b0;
    win_ext  = 1'b0;
    lost_ext = 1'b0;
    win_cmd  = NONE;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (src_valid_i[i] && (src_cmd_i[i] != NONE)) begin
        if (win_any) begin
          lost_ext = 1'b1;
        end else begin
          win_any = 1'b1;
          win_ext = 1'b1;
          win_cmd = src_cmd_i[i];
        end
      end
    end
    if (!win_any && grav_req) begin
      win_any = 1'b1;
      win_cmd = DOWN;
    end
  end

  assign pop  = cmd_valid_o & cmd_ready_i & ~flush_i;
  assign push = win_any & (~fifo_full | pop) & ~flush_i;

  cmd_fifo #(
    .Depth (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (win_cmd),
    .pop_i   (cmd_ready_i),
    .rdata_o (cmd_o),
    .valid_o (cmd_valid_o),
    .full_o  (fifo_full),
    .count_o (count_o)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else if (!flush_i) begin
      // A blocked gravity winner stays pending, so only external losses count.
      if (win_ext && fifo_full && !pop) overflow_q <= 1'b1;
      if (lost_ext)                     dropped_q  <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;
  assign dropped_o  = dropped_q;

`ifdef CTRL_GRAVITY_EN
  localparam int unsigned ProdW = 32 + LEVEL_W;

  logic [ProdW-1:0] grav_prod;
  logic [31:0]      grav_period, grav_limit;
  logic [31:0]      grav_cnt_q, grav_cnt_d;
  logic             grav_pend_q, grav_pend_d;

  // period = max(TICK_BASE - level*TICK_STEP, TICK_MIN) with a saturating subtract.
  always_comb begin
    grav_prod = ProdW'(TICK_STEP) * ProdW'(level_i);
    if (grav_prod >= ProdW'(TICK_BASE)) grav_period = 32'd0;
    else                                grav_period = TICK_BASE - grav_prod[31:0];
    if (grav_period < TICK_MIN) grav_period = TICK_MIN;
    grav_limit = (grav_period == 32'd0) ? 32'd0 : grav_period - 32'd1;
  end

  always_comb begin
    grav_cnt_d  = grav_cnt_q;
    grav_pend_d = grav_pend_q;
    if (flush_i || (push && (win_cmd == DOWN))) begin
      // Any accepted DOWN, external or gravity, restarts the interval.
      grav_cnt_d  = 32'd0;
      grav_pend_d = 1'b0;
    end else if (!grav_pend_q) begin
      if (grav_cnt_q >= grav_limit) begin
        grav_cnt_d  = 32'd0;
        grav_pend_d = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grav_cnt_q  <= 32'd0;
      grav_pend_q <= 1'b0;
    end else begin
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
    end
  end

  assign grav_req = grav_pend_q;
`else
  logic unused_grav;
  assign unused_grav = ^{level_i, TICK_BASE, TICK_STEP, TICK_MIN};
  assign grav_req    = 1'b0;
`endif

endmodule

// File: doc/control_queue.md
# control_queue

Parametrised game-command front end: arbitrates NSRC pulse-style command sources (UART decoder, buttons, switches) plus an internal level-dependent gravity timer into one FIFO, and hands commands one at a time to the game state machine over a valid/ready handshake. Sits between the input decoders and the game core. Adds over the previous control block:
- any source count;
- power-of-two depth;
- flush;
- overflow/drop reporting;
- gravity period that shortens with level.

## Interface
- QDEPTH, 16: FIFO entries; power of two, ≥2.
- NSRC, 4: external command sources; source 0 has highest priority.
- LEVEL_W, 4: width of level input.
- TICK_BASE, 50_000_000: gravity period at level 0, in cycles.
- TICK_STEP, 3_000_000: period reduction per level.
- TICK_MIN, 5_000_000: period floor.

- clk, in, 1: clock.
- reset_n, in, 1: reset, synchronous, active-low.
- src_valid, in, NSRC: per-source one-cycle command strobe.
- src_cmd, in, NSRC×state_type: per-source command.
- level, in, LEVEL_W: current game level.
- flush, in, 1: synchronous queue and gravity clear.
- cmd_ready, in, 1: consumer accepts the head entry.
- cmd_valid, out, 1: queue non-empty.
- cmd, out, state_type: head entry; NONE when empty.
- count, out, $clog2(QDEPTH)+1: occupancy.
- overflow, out, 1: sticky; a winning command was lost to a full queue.
- dropped, out, 1: sticky; a valid source lost arbitration.

## Operation
- **Arbitration.** Candidates are sources with src_valid=1 and src_cmd≠NONE, plus the gravity pending flag as source NSRC (lowest priority, cmd DOWN). The lowest-index candidate wins. Losing external candidates set dropped. A losing gravity request stays pending; it is never dropped.
- **Push and pop.**
  - push = winner exists ∧ (count<QDEPTH ∨ pop).
  - pop = cmd_valid ∧ cmd_ready.
  - Push and pop may occur in the same cycle. When full with pop=1, the push succeeds and count is unchanged.
- **Overflow.** A winner exists, the queue is full and pop=0: the command is discarded and overflow sets. If the winner is gravity, it stays pending and overflow does not set.
- **Pointers.** rd_ptr and wr_ptr are $clog2(QDEPTH) bits and wrap naturally. count is one bit wider, so it distinguishes full from empty.
- **Gravity period.** period = max(TICK_BASE − level·TICK_STEP, TICK_MIN). The product is computed at full width with saturating subtraction; no underflow.
- **Gravity counter.**
  - grav_cnt increments each cycle while grav_pend=0.
  - When grav_cnt ≥ period−1: grav_pend←1 and grav_cnt←0.
  - A level change takes effect on the next compare. If grav_cnt already ≥ the new period−1, gravity fires on the next cycle.
  - Any pushed DOWN, external or gravity, clears grav_pend and grav_cnt.
- **Flush.** flush=1 overrides push and pop in that cycle. It sets count←0 and both pointers←0, and clears grav_cnt and grav_pend. Sticky flags are unaffected.
- **Reset.** Same effect as flush, and also clears overflow and dropped.
- **Reset values.** cmd_valid=0, cmd=NONE, count=0, overflow=0, dropped=0.

## Timing
- Push in cycle N: entry appears in count and cmd_valid at N+1.
- No empty bypass: a command pushed into an empty queue cannot be popped in the same cycle.
- cmd is read combinationally from mem[rd_ptr], gated to NONE when empty.
- pop advances rd_ptr at the clock edge. The next entry is visible the following cycle, so sustained throughput is one pop per cycle.
- Gravity: with no inputs, level=0 and empty queue, DOWN is pushed every period+1 cycles. That is period counting cycles plus one pending cycle.
- A reset_n or flush assertion in the middle of a gravity interval restarts the full interval from 0.

## Configuration
- CTRL_GRAVITY_EN defined: gravity timer, the level-derived period and the gravity candidate are built. level is used.
- CTRL_GRAVITY_EN undefined: no timer logic. Only external sources are arbitrated and level is ignored. Ports are identical in both builds.

## Structure
- state_type (NONE, LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR, WAIT) lives in shared package enum_type.
- Default TICK_BASE, TICK_STEP and TICK_MIN values are added to enum_type as localparams, so the top level and this block agree.
- Sub-module cmd_fifo holds storage, pointers, count, push/pop and flush. Arbitration, gravity and sticky flags stay in control_queue.

## Test plan
Bench uses QDEPTH=4, NSRC=3, TICK_BASE=20, TICK_STEP=4, TICK_MIN=8, with CTRL_GRAVITY_EN defined unless stated.

- Same-cycle arbitration: src0=LEFT, src2=ROTATE, cmd_ready=0 → one push only; cmd=LEFT next cycle, count=1, dropped=1.
- Fill and overflow: 5 pushes of RIGHT with cmd_ready=0 → count=4 and overflow=1. Then hold cmd_ready=1 → 4 pops of RIGHT, then cmd_valid=0 and cmd=NONE.
- Full with simultaneous push and pop: queue full, push HOLD with pop → count stays 4, overflow stays 0, HOLD is popped fourth.
- Gravity: level=0, idle, cmd_ready=0 → DOWN enqueued at cycles 21, 42, 63. With level=5, the period clamps to 8 → DOWN every 9 cycles.
- Gravity suppression: external DOWN pushed at gravity-counter 15, level 0 → next gravity DOWN 21 cycles later.
- Flush: assert flush with count=3 and grav_pend=1, and src0=DROP in the same cycle → count=0 and no push. The next gravity DOWN arrives a full period+1 later; sticky flags are retained.
